// File: rtl/mesi_pkg.sv
// Shared types for the MESI cache controller: line states, bus op codes and FSM states.
package mesi_pkg;

    typedef enum logic [1:0] {
        LineE = 2'b00,
        LineI = 2'b01,
        LineS = 2'b10,
        LineM = 2'b11
    } line_state_e;

    typedef enum logic [1:0] {
        BusNone       = 2'b00,
        BusReadMiss   = 2'b01,
        BusWriteMiss  = 2'b10,
        BusInvalidate = 2'b11
    } bus_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StBusWait,
        StResp
    } fsm_state_e;

    // State a valid line moves to when another cache's transaction is snooped.
    function automatic line_state_e snoop_next(input line_state_e cur, input bus_op_e op);
        line_state_e nxt;
        nxt = cur;
        case (op)
            BusReadMiss:                nxt = LineS;
            BusWriteMiss, BusInvalidate: nxt = LineI;
            default:                    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mesi_next_state.sv
// Combinational per-line MESI transition for processor requests: decides hit service,
// the bus op to issue, the state after a grant and whether the victim needs a write-back.
module mesi_next_state
    import mesi_pkg::*;
(
    input  line_state_e line_state_i,
    input  logic        req_write_i,
    input  logic        hit_i,
    input  logic        no_shared_i,
    input  bus_op_e     pend_op_i,
    output logic        need_bus_o,
    output bus_op_e     bus_op_o,
    output line_state_e hit_state_o,
    output line_state_e grant_state_o,
    output logic        write_back_o
);

    logic silent_hit;

    always_comb begin
        // A write to a shared copy still needs the bus to invalidate other holders.
        silent_hit  = hit_i && (!req_write_i || line_state_i == LineE || line_state_i == LineM);
        need_bus_o  = !silent_hit;
        hit_state_o = req_write_i ? LineM : line_state_i;

        if (!req_write_i) begin
            bus_op_o = BusReadMiss;
        end else if (hit_i) begin
            bus_op_o = BusInvalidate;
        end else begin
            bus_op_o = BusWriteMiss;
        end

        if (pend_op_i == BusReadMiss) begin
            grant_state_o = no_shared_i ? LineE : LineS;
        end else begin
            grant_state_o = LineM;
        end

        write_back_o = (pend_op_i == BusReadMiss || pend_op_i == BusWriteMiss) &&
                       (line_state_i == LineM);
    end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// Direct-mapped MESI cache controller (tags/states only) with a processor port and a snooping bus.
// Snoop handling is built only when MESI_SNOOP_EN is defined.
module mesi_cache_ctrl
    import mesi_pkg::*;
#(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned TAG_W     = 8,
    localparam int unsigned IDX_W    = $clog2(NUM_LINES),
    localparam int unsigned ADDR_W   = TAG_W + IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic [1:0]        bus_op_o,
    output logic              bus_write_back_o,
    input  logic              no_shared_i,
    input  logic              snoop_valid_i,
    input  logic [1:0]        snoop_op_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              snoop_flush_o
);

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    bus_op_e           op_q, op_d;
    logic              hit_q, hit_d;

    line_state_e       line_state_q [NUM_LINES];
    line_state_e       line_state_d [NUM_LINES];
    logic [TAG_W-1:0]  tag_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_d [NUM_LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    line_state_e       cur_state;
    logic              hit;

    logic              need_bus;
    bus_op_e           ns_bus_op;
    line_state_e       hit_state;
    line_state_e       grant_state;
    logic              write_back;

    logic [IDX_W-1:0]  snp_idx;
    line_state_e       snp_next;
    logic              snp_match;
    logic              snp_kill;

    assign idx       = addr_q[IDX_W-1:0];
    assign req_tag   = addr_q[ADDR_W-1:IDX_W];
    assign cur_state = line_state_q[idx];
    assign hit       = (tag_q[idx] == req_tag) && (cur_state != LineI);

    mesi_next_state u_next_state (
        .line_state_i  (cur_state),
        .req_write_i   (write_q),
        .hit_i         (hit),
        .no_shared_i   (no_shared_i),
        .pend_op_i     (op_q),
        .need_bus_o    (need_bus),
        .bus_op_o      (ns_bus_op),
        .hit_state_o   (hit_state),
        .grant_state_o (grant_state),
        .write_back_o  (write_back)
    );

`ifdef MESI_SNOOP_EN
    logic [TAG_W-1:0] snp_tag;
    line_state_e      snp_cur;
    bus_op_e          snp_op;
    logic             flush_q;

    assign snp_idx   = snoop_addr_i[IDX_W-1:0];
    assign snp_tag   = snoop_addr_i[ADDR_W-1:IDX_W];
    assign snp_cur   = line_state_q[snp_idx];
    assign snp_op    = bus_op_e'(snoop_op_i);
    assign snp_match = snoop_valid_i && (snp_op != BusNone) && (snp_cur != LineI) &&
                       (tag_q[snp_idx] == snp_tag);
    assign snp_next  = snoop_next(snp_cur, snp_op);
    // Another cache took ownership of our target: an upgrade must now fetch the line.
    assign snp_kill  = snp_match && (snp_next == LineI) && (snoop_addr_i == addr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= snp_match && (snp_cur == LineM);
        end
    end

    assign snoop_flush_o = flush_q;
`else
    logic unused_snoop;

    assign unused_snoop  = ^{snoop_valid_i, snoop_op_i, snoop_addr_i};
    assign snp_idx       = '0;
    assign snp_next      = LineI;
    assign snp_match     = 1'b0;
    assign snp_kill      = 1'b0;
    assign snoop_flush_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            op_q    <= BusNone;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            op_q    <= op_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        op_d    = op_q;
        hit_d   = hit_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    write_d = req_write_i;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (need_bus) begin
                    op_d    = (ns_bus_op == BusInvalidate && snp_kill) ? BusWriteMiss : ns_bus_op;
                    state_d = StBusWait;
                end else begin
                    hit_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StBusWait: begin
                if (op_q == BusInvalidate && snp_kill) begin
                    op_d = BusWriteMiss;
                end
                if (bus_gnt_i) begin
                    hit_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o      = (state_q == StIdle) && !rst_i;
        resp_valid_o     = (state_q == StResp);
        resp_hit_o       = (state_q == StResp) && hit_q;
        bus_req_o        = (state_q == StBusWait);
        bus_op_o         = bus_req_o ? op_q : BusNone;
        bus_write_back_o = bus_req_o && write_back;
    end

    // Line array: snoop first, local request updates applied last so they take priority
    always_comb begin
        line_state_d = line_state_q;
        tag_d        = tag_q;
        if (snp_match) begin
            line_state_d[snp_idx] = snp_next;
        end
        if (state_q == StLookup && !need_bus && write_q) begin
            line_state_d[idx] = hit_state;
        end
        if (state_q == StBusWait && bus_gnt_i) begin
            line_state_d[idx] = grant_state;
            tag_d[idx]        = req_tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                line_state_q[i] <= LineI;
                tag_q[i]        <= '0;
            end
        end else begin
            line_state_q <= line_state_d;
            tag_q        <= tag_d;
        end
    end

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Scoreboard bench for mesi_cache_ctrl; snoop expectations follow MESI_SNOOP_EN.
module tb_mesi_cache_ctrl;

    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned TAG_W     = 8;
    localparam int unsigned ADDR_W    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid, resp_hit;
    logic              bus_req, bus_gnt;
    logic [1:0]        bus_op;
    logic              bus_wb, no_shared;
    logic              snoop_valid;
    logic [1:0]        snoop_op;
    logic [ADDR_W-1:0] snoop_addr;
    logic              snoop_flush;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_q[$];

`ifdef MESI_SNOOP_EN
    localparam logic SnoopOn = 1'b1;
`else
    localparam logic SnoopOn = 1'b0;
`endif

    mesi_cache_ctrl #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_addr_i       (req_addr),
        .resp_valid_o     (resp_valid),
        .resp_hit_o       (resp_hit),
        .bus_req_o        (bus_req),
        .bus_gnt_i        (bus_gnt),
        .bus_op_o         (bus_op),
        .bus_write_back_o (bus_wb),
        .no_shared_i      (no_shared),
        .snoop_valid_i    (snoop_valid),
        .snoop_op_i       (snoop_op),
        .snoop_addr_i     (snoop_addr),
        .snoop_flush_o    (snoop_flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RespValid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("resp_unexpected", resp_valid, 1'b0);
            end else begin
                logic e;
                e = exp_q.pop_front();
                check_eq("resp_hit", resp_hit, e);
            end
        end
    end

    task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a, input logic push,
                            input logic exp_hit);
        int n = 0;
        @(posedge clk); #1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready", req_ready, 1'b1);
        req_write = wr;
        req_addr  = a;
        req_valid = 1'b1;
        if (push) exp_q.push_back(exp_hit);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_bus(input string tag, input logic [1:0] op, input logic wb);
        int n = 0;
        @(negedge clk);
        while (bus_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req"}, bus_req, 1'b1);
        check_eq({tag, "_op"}, bus_op, op);
        check_eq({tag, "_wb"}, bus_wb, wb);
    endtask

    task automatic grant(input int delay, input logic ns);
        repeat (delay) @(posedge clk);
        #1;
        bus_gnt   = 1'b1;
        no_shared = ns;
        @(posedge clk); #1;
        bus_gnt   = 1'b0;
        no_shared = 1'b0;
        check_eq("req_drop_after_gnt", bus_req, 1'b0);
        check_eq("op_none_after_gnt", bus_op, 2'b00);
        check_eq("resp_after_gnt", resp_valid, 1'b1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, resp_valid, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic snoop(input logic [1:0] op, input logic [ADDR_W-1:0] a);
        @(posedge clk); #1;
        snoop_valid = 1'b1;
        snoop_op    = op;
        snoop_addr  = a;
        @(posedge clk); #1;
        snoop_valid = 1'b0;
        snoop_op    = 2'b00;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        bus_gnt = 1'b0; no_shared = 1'b0;
        snoop_valid = 1'b0; snoop_op = 2'b00; snoop_addr = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_bus_req", bus_req, 1'b0);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_flush", snoop_flush, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            check_eq("rst_line_I", dut.line_state_q[i], 2'b01);
            check_eq("rst_tag_0", dut.tag_q[i], 0);
        end

        // Read miss 0x05, exclusive fill after a 3-cycle grant wait
        send_req(1'b0, 10'h005, 1'b1, 1'b0);
        check_eq("lookup_no_req", bus_req, 1'b0);
        wait_bus("rd05", 2'b01, 1'b0);
        grant(3, 1'b1);
        check_eq("line1_E", dut.line_state_q[1], 2'b00);
        check_eq("line1_tag1", dut.tag_q[1], 8'h01);
        wait_resp("rd05_resp");

        // Silent write hit on E: response two cycles after acceptance
        send_req(1'b1, 10'h005, 1'b1, 1'b1);
        check_eq("wr05_no_req", bus_req, 1'b0);
        check_eq("wr05_no_resp_yet", resp_valid, 1'b0);
        @(posedge clk); #1;
        check_eq("wr05_resp", resp_valid, 1'b1);
        check_eq("wr05_no_req2", bus_req, 1'b0);
        check_eq("line1_M", dut.line_state_q[1], 2'b11);
        wait_resp("wr05_done");

        // Conflict read 0x09 evicts the dirty line, shared fill
        send_req(1'b0, 10'h009, 1'b1, 1'b0);
        wait_bus("rd09", 2'b01, 1'b1);
        grant(1, 1'b0);
        check_eq("line1_S", dut.line_state_q[1], 2'b10);
        check_eq("line1_tag2", dut.tag_q[1], 8'h02);
        wait_resp("rd09_resp");

        // Upgrade on S, overtaken by a snooped WriteMiss before grant
        send_req(1'b1, 10'h009, 1'b1, 1'b0);
        wait_bus("inv09", 2'b11, 1'b0);
        snoop(2'b10, 10'h009);
        check_eq("inv09_op_after_snoop", bus_op, SnoopOn ? 2'b10 : 2'b11);
        check_eq("inv09_wb_after_snoop", bus_wb, 1'b0);
        check_eq("inv09_no_flush", snoop_flush, 1'b0);
        check_eq("line1_after_snoop", dut.line_state_q[1], SnoopOn ? 2'b01 : 2'b10);
        grant(0, 1'b1);
        check_eq("line1_M_after_gnt", dut.line_state_q[1], 2'b11);
        wait_resp("inv09_resp");

        // Snooped ReadMiss on an M line
        snoop(2'b01, 10'h009);
        check_eq("flush_pulse", snoop_flush, SnoopOn);
        check_eq("line1_after_rdsnoop", dut.line_state_q[1], SnoopOn ? 2'b10 : 2'b11);
        @(posedge clk); #1;
        check_eq("flush_one_cycle", snoop_flush, 1'b0);

        // Read hit on the surviving copy
        send_req(1'b0, 10'h009, 1'b1, 1'b1);
        wait_resp("rd09_hit");

        // Write miss to an empty line
        send_req(1'b1, 10'h00B, 1'b1, 1'b0);
        wait_bus("wm0b", 2'b10, 1'b0);
        grant(2, 1'b1);
        check_eq("line3_M", dut.line_state_q[3], 2'b11);
        wait_resp("wm0b_resp");

        // Maximum tag on index 0
        send_req(1'b0, 10'h3FC, 1'b1, 1'b0);
        wait_bus("rd3fc", 2'b01, 1'b0);
        grant(0, 1'b0);
        check_eq("line0_S", dut.line_state_q[0], 2'b10);
        check_eq("line0_tagFF", dut.tag_q[0], 8'hFF);
        wait_resp("rd3fc_resp");

        // Reset while waiting for the bus aborts the transaction
        send_req(1'b0, 10'h00F, 1'b0, 1'b0);
        wait_bus("rd0f", 2'b01, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_bus_req", bus_req, 1'b0);
        check_eq("abort_bus_op", bus_op, 2'b00);
        check_eq("abort_req_ready", req_ready, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_resp", resp_valid, 1'b0);
        end
        for (int i = 0; i < NUM_LINES; i++) begin
            check_eq("abort_line_I", dut.line_state_q[i], 2'b01);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_abort", req_ready, 1'b1);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
